// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, ALU selects, flag indices, FSM states.
package alu_pkg;

    localparam int DATA_WIDTH_DEFAULT = 16;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_CMP = 4'd6;
    localparam logic [3:0] OP_MUL = 4'd7;
    localparam logic [3:0] OP_LSH = 4'd8;

    localparam logic [2:0] SEL_ADD = 3'b000;
    localparam logic [2:0] SEL_SUB = 3'b001;
    localparam logic [2:0] SEL_AND = 3'b010;
    localparam logic [2:0] SEL_OR  = 3'b011;
    localparam logic [2:0] SEL_XOR = 3'b100;
    localparam logic [2:0] SEL_NOT = 3'b101;

    localparam int FLAG_C = 4;
    localparam int FLAG_L = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MUL_LOOP,
        ST_SHL_LOOP,
        ST_RESP
    } seq_state_t;

    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_LSH;
    endfunction

    // LSH only reaches the single-cycle path with a zero count, where it is an OR with zero.
    function automatic logic [2:0] op_select(input logic [3:0] op);
        case (op)
            OP_ADD:  return SEL_ADD;
            OP_SUB:  return SEL_SUB;
            OP_AND:  return SEL_AND;
            OP_OR:   return SEL_OR;
            OP_XOR:  return SEL_XOR;
            OP_NOT:  return SEL_NOT;
            OP_CMP:  return SEL_SUB;
            OP_LSH:  return SEL_OR;
            default: return SEL_ADD;
        endcase
    endfunction

    function automatic logic op_sets_psr(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP) ||
               (op == OP_MUL) || (op == OP_LSH);
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/response handshake bundle between the datapath and the ALU sequencer.
interface alu_op_sequencer_if #(
    parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH_DEFAULT
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic [3:0]            req_op;
    logic [DATA_WIDTH-1:0] req_a;
    logic [DATA_WIDTH-1:0] req_b;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_result;
    logic [4:0]            rsp_flags;
    logic                  rsp_wb;
    logic                  rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_wb, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_wb, rsp_err
    );

endinterface

// File: rtl/alu_op_sequencer.sv
// Drives the shared ALU for single-cycle ops and iterates it for MUL/LSH; owns the PSR.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_op_sequencer_if.slave     bus,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [2:0]            alu_select,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic [4:0]            alu_flags,
    output logic [4:0]            psr_flags,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    seq_state_t            state, next_state;
    logic [3:0]            op_q;
    logic [DATA_WIDTH-1:0] a_q;      // operand A, reused as the MUL multiplicand
    logic [DATA_WIDTH-1:0] b_q;      // operand B, reused as the MUL multiplier
    logic [DATA_WIDTH-1:0] acc;
    logic [CNT_W-1:0]      cnt;

    logic [DATA_WIDTH-1:0] rsp_result_q;
    logic [4:0]            rsp_flags_q;
    logic                  rsp_wb_q;
    logic                  rsp_err_q;
    logic [4:0]            psr_q;

    logic [DATA_WIDTH-1:0] fin_result;
    logic [4:0]            fin_flags;
    logic [4:0]            zn_flags;
    logic                  fin_wb;
    logic                  fin_err;
    logic                  legal;

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.rsp_valid  = (state == ST_RESP);
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flags  = rsp_flags_q;
    assign bus.rsp_wb     = rsp_wb_q;
    assign bus.rsp_err    = rsp_err_q;
    assign psr_flags      = psr_q;
    assign busy           = (state != ST_IDLE);
    assign legal          = op_legal(op_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        alu_a      = '0;
        alu_b      = '0;
        alu_select = SEL_ADD;
        fin_result = alu_out;
        fin_wb     = 1'b1;
        fin_err    = 1'b0;
        zn_flags   = '0;
        zn_flags[FLAG_Z] = (alu_out == '0);
        zn_flags[FLAG_N] = alu_out[DATA_WIDTH-1];
        fin_flags  = zn_flags;

        case (state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (bus.req_op == OP_MUL) begin
                        next_state = ST_MUL_LOOP;
                    end else if (bus.req_op == OP_LSH && bus.req_b[3:0] != 4'd0) begin
                        next_state = ST_SHL_LOOP;
                    end else begin
                        next_state = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                // Illegal ops leave the ALU idle and report zeros with the error bit.
                alu_a      = legal ? a_q : '0;
                alu_b      = (legal && op_q != OP_LSH) ? b_q : '0;
                alu_select = op_select(op_q);
                fin_result = legal ? alu_out : '0;
                fin_flags  = legal ? alu_flags : 5'd0;
                fin_wb     = legal && (op_q != OP_CMP);
                fin_err    = !legal;
                next_state = ST_RESP;
            end
            ST_MUL_LOOP: begin
                alu_a = acc;
                alu_b = b_q[0] ? a_q : '0;
                if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
                    next_state = ST_RESP;
                end
            end
            ST_SHL_LOOP: begin
                alu_a = acc;
                alu_b = acc;
                fin_flags[FLAG_C] = alu_flags[FLAG_C];
                if (cnt == CNT_W'(1)) begin
                    next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            acc          <= '0;
            cnt          <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_wb_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
            psr_q        <= '0;
        end else begin
            if (state == ST_IDLE && bus.req_valid) begin
                op_q <= bus.req_op;
                a_q  <= bus.req_a;
                b_q  <= bus.req_b;
                acc  <= (bus.req_op == OP_LSH) ? bus.req_a : '0;
                cnt  <= (bus.req_op == OP_LSH) ? CNT_W'(bus.req_b[3:0]) : '0;
            end
            if (state == ST_MUL_LOOP) begin
                acc <= alu_out;
                a_q <= a_q << 1;
                b_q <= b_q >> 1;
                cnt <= cnt + CNT_W'(1);
            end
            if (state == ST_SHL_LOOP) begin
                acc <= alu_out;
                cnt <= cnt - CNT_W'(1);
            end
            if (state != ST_RESP && next_state == ST_RESP) begin
                rsp_result_q <= fin_result;
                rsp_flags_q  <= fin_flags;
                rsp_wb_q     <= fin_wb;
                rsp_err_q    <= fin_err;
                if (op_sets_psr(op_q)) begin
                    psr_q <= fin_flags;
                end
            end
        end
    end

endmodule
